// File: rtl/spi_target_pkg.sv
// ---------------------------------------------------------------------------
// spi_target_pkg
// Shared types and constants for the SPI target register bridge.
//   state_e        : transaction FSM states
//   CMD_RD_BIT     : bit of the command byte that selects read (1) / write (0)
//   MIN_SCK_RATIO  : smallest allowed f(CLK)/f(SPI_CCK) ratio
// ---------------------------------------------------------------------------
package spi_target_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } state_e;

  localparam int CMD_RD_BIT    = 7;
  localparam int MIN_SCK_RATIO = 8;

endpackage

// File: rtl/spi_target_sync.sv
// ---------------------------------------------------------------------------
// spi_target_sync
// Brings the three SPI pins into the system clock domain and derives
// single-cycle SCK edge pulses. Every output is registered, so a pin edge
// shows up as a pulse SYNC_STAGES+1 clocks later, with SEL and MOSI aligned
// to the same pipeline depth.
// Ports:
//   i_clk, i_sysreset          system clock, synchronous active-high reset
//   i_spi_cck/ss_n/mosi        raw SPI pins
//   o_sck_rise, o_sck_fall     one-cycle pulses on synchronized SCK edges
//   o_sel                      synchronized select (= ~SS_N)
//   o_mosi_s                   synchronized MOSI
// ---------------------------------------------------------------------------
module spi_target_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_sysreset,
  input  logic i_spi_cck,
  input  logic i_spi_ss_n,
  input  logic i_spi_mosi,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_sel,
  output logic o_mosi_s
);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ss_n_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_sck_rise;
  logic                   r_sck_fall;
  logic                   r_sel;
  logic                   r_mosi_s;

  // NOTE: every flop here uses <= so each stage samples the previous stage's
  // old value; blocking assignments would collapse the chain into one flop.
  always_ff @(posedge i_clk) begin
    if (i_sysreset) begin
      // Idle pin levels, so reset release never looks like an SCK edge or a
      // select assertion.
      r_sck_sync  <= '0;
      r_ss_n_sync <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_sck_rise  <= 1'b0;
      r_sck_fall  <= 1'b0;
      r_sel       <= 1'b0;
      r_mosi_s    <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0],  i_spi_cck};
      r_ss_n_sync <= {r_ss_n_sync[SYNC_STAGES-2:0], i_spi_ss_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
      r_sck_rise  <= r_sck_sync[SYNC_STAGES-1] & ~r_sck_d;
      r_sck_fall  <= ~r_sck_sync[SYNC_STAGES-1] & r_sck_d;
      r_sel       <= ~r_ss_n_sync[SYNC_STAGES-1];
      r_mosi_s    <= r_mosi_sync[SYNC_STAGES-1];
    end
  end

  assign o_sck_rise = r_sck_rise;
  assign o_sck_fall = r_sck_fall;
  assign o_sel      = r_sel;
  assign o_mosi_s   = r_mosi_s;

endmodule

// File: rtl/spi_target_regs.sv
// ---------------------------------------------------------------------------
// spi_target_regs
// SPI mode-0 target bridging SPI frames onto a byte-wide register bus.
// Frame: command byte {rd_flag, addr[6:0]} followed by data bytes; the
// address auto-increments per data byte and wraps at 2^ADDR_W.
// Ports:
//   i_clk, i_sysreset            system clock, synchronous active-high reset
//   i_spi_cck/ss_n/mosi          SPI pins from the master (oversampled)
//   o_spi_miso, o_spi_miso_oe    serial read data and its output enable
//   o_reg_addr, o_reg_wdata      register bus address / write data
//   o_reg_wr, o_reg_rd           one-cycle write / read strobes
//   i_reg_rdata                  read data, valid one clock after o_reg_rd
//   o_busy                       transaction open (FSM not idle)
// ---------------------------------------------------------------------------
module spi_target_regs
  import spi_target_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_sysreset,
  input  logic              i_spi_cck,
  input  logic              i_spi_ss_n,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic              o_spi_miso_oe,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [7:0]        o_reg_wdata,
  output logic              o_reg_wr,
  output logic              o_reg_rd,
  input  logic [7:0]        i_reg_rdata,
  output logic              o_busy
);

  logic w_sck_rise;
  logic w_sck_fall;
  logic w_sel;
  logic w_mosi_s;

  spi_target_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk      (i_clk),
    .i_sysreset (i_sysreset),
    .i_spi_cck  (i_spi_cck),
    .i_spi_ss_n (i_spi_ss_n),
    .i_spi_mosi (i_spi_mosi),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_sel      (w_sel),
    .o_mosi_s   (w_mosi_s)
  );

  state_e            r_state;
  logic [2:0]        r_bit_cnt;
  logic [6:0]        r_shift;    // only 7 bits are kept; the 8th arrives live
  logic [7:0]        r_tx;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_wr;
  logic              r_rd;
  logic              r_rd_d;     // read data due on i_reg_rdata this cycle

  logic [7:0]        w_shift_next;
  logic              w_last_bit;

  assign w_shift_next = {r_shift, w_mosi_s};
  assign w_last_bit   = (r_bit_cnt == 3'd7);

  always_ff @(posedge i_clk) begin
    if (i_sysreset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tx      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_rd_d    <= 1'b0;
    end else begin
      // Strobes default low, so any assignment below makes a one-cycle pulse.
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_rd_d <= r_rd;

      if (!w_sel) begin
        // Dropping select abandons partial bytes and any pending read data.
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_bit_cnt <= '0;
            r_state   <= ST_CMD;
          end

          ST_CMD: begin
            if (w_sck_rise) begin
              r_shift   <= w_shift_next[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_addr <= w_shift_next[ADDR_W-1:0];
                if (w_shift_next[CMD_RD_BIT]) begin
                  r_rd    <= 1'b1;
                  r_state <= ST_RD;
                end else begin
                  r_state <= ST_WR;
                end
              end
            end
          end

          ST_WR: begin
            // Advance the address only after the strobe so the bus sees a
            // stable address for the whole write cycle.
            if (r_wr) begin
              r_addr <= r_addr + 1'b1;
            end
            if (w_sck_rise) begin
              r_shift   <= w_shift_next[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_wr    <= 1'b1;
                r_wdata <= w_shift_next;
              end
            end
          end

          ST_RD: begin
            // The falling edge right after a byte boundary (bit counter at 0)
            // launches the freshly loaded MSB, so it must not shift.
            if (r_rd_d) begin
              r_tx <= i_reg_rdata;
            end else if (w_sck_fall && (r_bit_cnt != 3'd0)) begin
              r_tx <= {r_tx[6:0], 1'b0};
            end
            if (w_sck_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_addr <= r_addr + 1'b1;
                r_rd   <= 1'b1;
              end
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_spi_miso    = (r_state == ST_RD) & r_tx[7];
  assign o_spi_miso_oe = w_sel;
  assign o_reg_addr    = r_addr;
  assign o_reg_wdata   = r_wdata;
  assign o_reg_wr      = r_wr;
  assign o_reg_rd      = r_rd;
  assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_target_regs.sv
// ---------------------------------------------------------------------------
// tb_spi_target_regs
// Directed bench for spi_target_regs: acts as SPI master (SCK = CLK/8) and
// as a register file whose read data is ~address, one clock after REG_RD.
// ---------------------------------------------------------------------------
module tb_spi_target_regs;
  import spi_target_pkg::*;

  localparam int ADDR_W      = 7;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = MIN_SCK_RATIO / 2;

  logic              clk = 1'b0;
  logic              sysreset;
  logic              spi_cck;
  logic              spi_ss_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_wr;
  logic              reg_rd;
  logic [7:0]        reg_rdata = 8'h00;
  logic              busy;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [7:0]        wr_data_q[$];
  logic [ADDR_W-1:0] rd_addr_q[$];
  logic              both_seen = 1'b0;
  logic              busy_seen = 1'b0;
  logic              oe_seen   = 1'b0;

  always #5 clk = ~clk;

  spi_target_regs #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .i_clk         (clk),
    .i_sysreset    (sysreset),
    .i_spi_cck     (spi_cck),
    .i_spi_ss_n    (spi_ss_n),
    .i_spi_mosi    (spi_mosi),
    .o_spi_miso    (spi_miso),
    .o_spi_miso_oe (spi_miso_oe),
    .o_reg_addr    (reg_addr),
    .o_reg_wdata   (reg_wdata),
    .o_reg_wr      (reg_wr),
    .o_reg_rd      (reg_rd),
    .i_reg_rdata   (reg_rdata),
    .o_busy        (busy)
  );

  // Register file model: read data is the inverted address, one clock late.
  always @(posedge clk) begin
    if (reg_rd) reg_rdata <= ~{1'b0, reg_addr};
  end

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reg_wr) begin
      wr_addr_q.push_back(reg_addr);
      wr_data_q.push_back(reg_wdata);
    end
    if (reg_rd) rd_addr_q.push_back(reg_addr);
    if (reg_wr && reg_rd) both_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (spi_miso_oe) oe_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    busy_seen = 1'b0;
    oe_seen   = 1'b0;
  endtask

  // Mode 0 master: set MOSI while SCK low, sample MISO just before the rise.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx = {rx[6:0], spi_miso};
      spi_cck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_cck = 1'b0;
    end
  endtask

  task automatic frame_start();
    spi_ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (HALF) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rx;
    int         cyc;

    sysreset = 1'b1;
    spi_cck  = 1'b0;
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);

    // Reset values
    check("rst_miso",  {31'd0, spi_miso},    32'd0);
    check("rst_oe",    {31'd0, spi_miso_oe}, 32'd0);
    check("rst_wr",    {31'd0, reg_wr},      32'd0);
    check("rst_rd",    {31'd0, reg_rd},      32'd0);
    check("rst_busy",  {31'd0, busy},        32'd0);
    check("rst_addr",  {25'd0, reg_addr},    32'd0);
    check("rst_wdata", {24'd0, reg_wdata},   32'd0);
    sysreset = 1'b0;
    repeat (4) @(negedge clk);

    // Write burst: 0x05, A5 3C FF
    clear_logs();
    frame_start();
    spi_bits(8'h05, 8, rx);
    spi_bits(8'hA5, 8, rx);
    spi_bits(8'h3C, 8, rx);
    spi_bits(8'hFF, 8, rx);
    frame_end();
    check("wb_wr_cnt", wr_addr_q.size(), 3);
    check("wb_rd_cnt", rd_addr_q.size(), 0);
    check("wb_a0", {25'd0, wr_addr_q[0]}, 32'h05);
    check("wb_d0", {24'd0, wr_data_q[0]}, 32'hA5);
    check("wb_a1", {25'd0, wr_addr_q[1]}, 32'h06);
    check("wb_d1", {24'd0, wr_data_q[1]}, 32'h3C);
    check("wb_a2", {25'd0, wr_addr_q[2]}, 32'h07);
    check("wb_d2", {24'd0, wr_data_q[2]}, 32'hFF);
    check("wb_busy_idle", {31'd0, busy}, 32'd0);

    // Read burst: 0x90, two data bytes
    clear_logs();
    frame_start();
    spi_bits(8'h90, 8, rx);
    check("rb_oe", {31'd0, spi_miso_oe}, 32'd1);
    spi_bits(8'h00, 8, rx);
    check("rb_byte0", {24'd0, rx}, 32'hEF);
    spi_bits(8'h00, 8, rx);
    check("rb_byte1", {24'd0, rx}, 32'hEE);
    frame_end();
    check("rb_rd_cnt", rd_addr_q.size(), 3);
    check("rb_wr_cnt", wr_addr_q.size(), 0);
    check("rb_a0", {25'd0, rd_addr_q[0]}, 32'h10);
    check("rb_a1", {25'd0, rd_addr_q[1]}, 32'h11);
    check("rb_a2", {25'd0, rd_addr_q[2]}, 32'h12);
    check("rb_miso_idle", {31'd0, spi_miso}, 32'd0);

    // Address wrap: 0x7F, 11 22
    clear_logs();
    frame_start();
    spi_bits(8'h7F, 8, rx);
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h22, 8, rx);
    frame_end();
    check("wrap_cnt", wr_addr_q.size(), 2);
    check("wrap_a0", {25'd0, wr_addr_q[0]}, 32'h7F);
    check("wrap_d0", {24'd0, wr_data_q[0]}, 32'h11);
    check("wrap_a1", {25'd0, wr_addr_q[1]}, 32'h00);
    check("wrap_d1", {24'd0, wr_data_q[1]}, 32'h22);

    // Abort after 5 bits of the second data byte
    clear_logs();
    frame_start();
    spi_bits(8'h20, 8, rx);
    spi_bits(8'h5A, 8, rx);
    spi_bits(8'hB6, 5, rx);
    spi_ss_n = 1'b1;
    cyc = 0;
    while (busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_busy_low", {31'd0, busy}, 32'd0);
    check("abort_busy_lat", {31'd0, (cyc <= SYNC_STAGES + 2)}, 32'd1);
    repeat (8) @(negedge clk);
    check("abort_wr_cnt", wr_addr_q.size(), 1);
    check("abort_a0", {25'd0, wr_addr_q[0]}, 32'h20);
    check("abort_d0", {24'd0, wr_data_q[0]}, 32'h5A);
    clear_logs();
    frame_start();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h77, 8, rx);
    frame_end();
    check("post_abort_cnt", wr_addr_q.size(), 1);
    check("post_abort_a", {25'd0, wr_addr_q[0]}, 32'h03);
    check("post_abort_d", {24'd0, wr_data_q[0]}, 32'h77);

    // Reset in the middle of a read (addr 0x40, 3 bits into the first byte)
    clear_logs();
    frame_start();
    spi_bits(8'hC0, 8, rx);
    spi_bits(8'h00, 3, rx);
    check("mid_busy", {31'd0, busy}, 32'd1);
    sysreset = 1'b1;
    spi_ss_n = 1'b1;
    @(negedge clk);
    check("mr_miso",  {31'd0, spi_miso},    32'd0);
    check("mr_oe",    {31'd0, spi_miso_oe}, 32'd0);
    check("mr_wr",    {31'd0, reg_wr},      32'd0);
    check("mr_rd",    {31'd0, reg_rd},      32'd0);
    check("mr_busy",  {31'd0, busy},        32'd0);
    check("mr_addr",  {25'd0, reg_addr},    32'd0);
    check("mr_wdata", {24'd0, reg_wdata},   32'd0);
    repeat (2) @(negedge clk);
    sysreset = 1'b0;
    repeat (6) @(negedge clk);
    clear_logs();
    frame_start();
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'hC3, 8, rx);
    frame_end();
    check("post_rst_cnt", wr_addr_q.size(), 1);
    check("post_rst_a", {25'd0, wr_addr_q[0]}, 32'h0A);
    check("post_rst_d", {24'd0, wr_data_q[0]}, 32'hC3);

    // SCK toggling with SS_N high
    clear_logs();
    spi_bits(8'hC5, 8, rx);
    spi_bits(8'h3A, 8, rx);
    repeat (8) @(negedge clk);
    check("idle_wr_cnt", wr_addr_q.size(), 0);
    check("idle_rd_cnt", rd_addr_q.size(), 0);
    check("idle_busy",   {31'd0, busy_seen}, 32'd0);
    check("idle_oe",     {31'd0, oe_seen},   32'd0);

    check("never_both_strobes", {31'd0, both_seen}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
